// File: rtl/door_lock_ctrl.sv
// Keypad PIN sequencer: turns held key codes into single press events, checks the
// entered PIN against a re-programmable code and drives unlock, error and alarm.

module door_lock_ctrl #(
   parameter int unsigned           CODE_LEN        = 4,
   parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE    = 16'h1234,
   parameter int unsigned           DEBOUNCE_CYCLES = 500000,
   parameter int unsigned           UNLOCK_CYCLES   = 500000000,
   parameter int unsigned           ERROR_CYCLES    = 100000000,
   parameter int unsigned           LOCKOUT_CYCLES  = 32'd3000000000,
   parameter int unsigned           TIMEOUT_CYCLES  = 1000000000,
   parameter int unsigned           MAX_FAILS       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       unlock,
   output logic       error,
   output logic       alarm,
   output logic [3:0] digit_count,
   output logic [2:0] fail_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_UNLOCKED = 3'd3,
      ST_PROGRAM  = 3'd4,
      ST_ERROR    = 3'd5,
      ST_LOCKOUT  = 3'd6
   } state_t;

   localparam logic [3:0]  KEY_ENTER    = 4'hA;
   localparam logic [3:0]  KEY_PROG     = 4'hB;
   localparam logic [3:0]  KEY_CLEAR    = 4'hC;
   localparam logic [3:0]  KEY_LOCK     = 4'hD;
   localparam logic [3:0]  CODE_LEN_W   = 4'(CODE_LEN);
   localparam logic [2:0]  MAX_F        = 3'(MAX_FAILS);
   localparam logic [31:0] DEB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] DEB_MAX      = 32'(DEBOUNCE_CYCLES);
   localparam logic [31:0] UNLOCK_LAST  = 32'(UNLOCK_CYCLES - 1);
   localparam logic [31:0] ERROR_LAST   = 32'(ERROR_CYCLES - 1);
   localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [1:0]  validSync_q;
   logic [3:0]  codeSync1_q, codeSync2_q, runCode_q;
   logic [31:0] runCnt_q, relCnt_q, timer_q, limitLast;
   logic        armed_q, syncValid, isDigit, pressFire, timed, timerExpire, timerReload, lockoutExit;
   logic [3:0]  syncCode;

   state_t                  state_q, state_d;
   logic [4*CODE_LEN-1:0]   buffer_q, buffer_d, code_q, code_d, shifted;
   logic [3:0]              digitCount_q, digitCount_d;
   logic [2:0]              failCount_q, failCount_d, nextFails;

   assign syncValid = validSync_q[1];
   assign syncCode  = codeSync2_q;
   assign isDigit   = syncCode <= 4'd9;
   // runCnt_q counts earlier stable cycles, so the press fires on the DEBOUNCE_CYCLES-th one
   assign pressFire = armed_q && syncValid && (runCnt_q == DEB_LAST) &&
                      ((runCnt_q == 32'd0) || (syncCode == runCode_q));
   assign lockoutExit = (state_q == ST_LOCKOUT) && timerExpire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validSync_q <= '0;
         codeSync1_q <= '0;
         codeSync2_q <= '0;
         runCode_q   <= '0;
         runCnt_q    <= '0;
         relCnt_q    <= '0;
         armed_q     <= 1'b1;
      end else begin
         validSync_q <= {validSync_q[0], key_valid};
         codeSync1_q <= key_code;
         codeSync2_q <= codeSync1_q;
         if (!syncValid) begin
            runCnt_q <= '0;
         end else if ((runCnt_q == 32'd0) || (syncCode != runCode_q)) begin
            runCnt_q  <= 32'd1;
            runCode_q <= syncCode;
         end else if (runCnt_q != DEB_MAX) begin
            runCnt_q <= runCnt_q + 32'd1;
         end
         if (syncValid)
            relCnt_q <= '0;
         else if (relCnt_q != DEB_MAX)
            relCnt_q <= relCnt_q + 32'd1;
         // a key still held when lockout ends must be released before it counts
         if (pressFire || (lockoutExit && syncValid))
            armed_q <= 1'b0;
         else if (!syncValid && (relCnt_q >= DEB_LAST))
            armed_q <= 1'b1;
      end
   end

   always_comb begin
      timed     = 1'b1;
      limitLast = '0;
      case (state_q)
         ST_ENTRY, ST_PROGRAM: limitLast = TIMEOUT_LAST;
         ST_UNLOCKED:          limitLast = UNLOCK_LAST;
         ST_ERROR:             limitLast = ERROR_LAST;
         ST_LOCKOUT:           limitLast = LOCKOUT_LAST;
         default:              timed = 1'b0;
      endcase
   end

   assign timerExpire = timed && (timer_q == limitLast);
   assign timerReload = !timed || (state_d != state_q) ||
                        (pressFire && ((state_q == ST_ENTRY) || (state_q == ST_PROGRAM)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         buffer_q     <= '0;
         code_q       <= DEFAULT_CODE;
         digitCount_q <= '0;
         failCount_q  <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         buffer_q     <= buffer_d;
         code_q       <= code_d;
         digitCount_q <= digitCount_d;
         failCount_q  <= failCount_d;
         timer_q      <= timerReload ? 32'd0 : timer_q + 32'd1;
      end
   end

   // timer expiry is tested before any press so a coincident press is dropped
   always_comb begin
      state_d      = state_q;
      buffer_d     = buffer_q;
      code_d       = code_q;
      digitCount_d = digitCount_q;
      failCount_d  = failCount_q;
      shifted      = buffer_q << 4;
      shifted[3:0] = syncCode;
      nextFails    = (failCount_q >= MAX_F) ? MAX_F : failCount_q + 3'd1;
      case (state_q)
         ST_IDLE: begin
            if (pressFire && isDigit) begin
               buffer_d      = '0;
               buffer_d[3:0] = syncCode;
               digitCount_d  = 4'd1;
               state_d       = ST_ENTRY;
            end
         end
         ST_ENTRY, ST_PROGRAM: begin
            if (timerExpire) begin
               state_d      = ST_IDLE;
               buffer_d     = '0;
               digitCount_d = '0;
            end else if (pressFire) begin
               if (isDigit) begin
                  if (digitCount_q < CODE_LEN_W) begin
                     buffer_d     = shifted;
                     digitCount_d = digitCount_q + 4'd1;
                  end
               end else if (syncCode == KEY_CLEAR) begin
                  state_d      = (state_q == ST_ENTRY) ? ST_IDLE : ST_UNLOCKED;
                  buffer_d     = '0;
                  digitCount_d = '0;
               end else if (syncCode == KEY_ENTER) begin
                  if (state_q == ST_ENTRY) begin
                     state_d = ST_CHECK;
                  end else begin
                     buffer_d     = '0;
                     digitCount_d = '0;
                     if (digitCount_q == CODE_LEN_W) begin
                        code_d  = buffer_q;
                        state_d = ST_UNLOCKED;
                     end else begin
                        state_d = ST_ERROR;
                     end
                  end
               end
            end
         end
         ST_CHECK: begin
            buffer_d     = '0;
            digitCount_d = '0;
            if ((digitCount_q == CODE_LEN_W) && (buffer_q == code_q)) begin
               failCount_d = '0;
               state_d     = ST_UNLOCKED;
            end else begin
               failCount_d = nextFails;
               state_d     = (nextFails == MAX_F) ? ST_LOCKOUT : ST_ERROR;
            end
         end
         ST_UNLOCKED: begin
            if (timerExpire)
               state_d = ST_IDLE;
            else if (pressFire && (syncCode == KEY_LOCK))
               state_d = ST_IDLE;
            else if (pressFire && (syncCode == KEY_PROG))
               state_d = ST_PROGRAM;
         end
         ST_ERROR: begin
            if (timerExpire)
               state_d = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (timerExpire) begin
               state_d     = ST_IDLE;
               failCount_d = '0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            buffer_d     = '0;
            digitCount_d = '0;
         end
      endcase
   end

   always_comb begin
      unlock      = (state_q == ST_UNLOCKED) || (state_q == ST_PROGRAM);
      error       = state_q == ST_ERROR;
      alarm       = state_q == ST_LOCKOUT;
      digit_count = digitCount_q;
      fail_count  = failCount_q;
      state       = state_q;
   end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: a cycle model built from press/timer rules is compared
// every cycle, and directed key sequences add hand-computed literal checks.

module tb_door_lock_ctrl;

   localparam int DEB     = 4;
   localparam int T_UNLK  = 50;
   localparam int T_ERR   = 20;
   localparam int T_LOCK  = 80;
   localparam int T_IDLE  = 200;
   localparam int S_IDLE = 0, S_ENTRY = 1, S_CHECK = 2, S_UNLOCKED = 3;
   localparam int S_PROGRAM = 4, S_ERROR = 5, S_LOCKOUT = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] keyCode;
   logic       keyValid;
   logic       unlock, error, alarm;
   logic [3:0] digitCount;
   logic [2:0] failCnt, stateOut;

   int  checkCount = 0;
   int  errCount   = 0;
   bit  cmpEn      = 0;
   int  unlockRun = 0, errorRun = 0, alarmRun = 0;
   int  lastUnlockRun = 0, lastErrorRun = 0, lastAlarmRun = 0;

   int          mState, mLeft, mCount, mFails, mRun, mRel;
   logic [15:0] mBuf, mCode;
   logic        mS1v, mS2v, mArmed;
   logic [3:0]  mS1c, mS2c, mRunCode;

   always #5 clk = ~clk;

   door_lock_ctrl #(
      .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .DEBOUNCE_CYCLES(DEB),
      .UNLOCK_CYCLES(T_UNLK), .ERROR_CYCLES(T_ERR), .LOCKOUT_CYCLES(T_LOCK),
      .TIMEOUT_CYCLES(T_IDLE), .MAX_FAILS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_code(keyCode), .key_valid(keyValid),
      .unlock(unlock), .error(error), .alarm(alarm), .digit_count(digitCount),
      .fail_count(failCnt), .state(stateOut)
   );

   function automatic int limitOf(input int s);
      case (s)
         S_ENTRY, S_PROGRAM: return T_IDLE;
         S_UNLOCKED:         return T_UNLK;
         S_ERROR:            return T_ERR;
         S_LOCKOUT:          return T_LOCK;
         default:            return 0;
      endcase
   endfunction

   task automatic modelReset();
      mState = S_IDLE; mLeft = 0; mCount = 0; mFails = 0; mRun = 0; mRel = 0;
      mBuf = '0; mCode = 16'h1234; mArmed = 1'b1;
      mS1v = 1'b0; mS2v = 1'b0; mS1c = '0; mS2c = '0; mRunCode = '0;
   endtask

   // One clock of the reference behaviour, using the synchronised inputs seen before the edge
   task automatic modelStep();
      logic       v;
      logic [3:0] c;
      bit         fire, expire, reload;
      int         nxt;
      v = mS2v; c = mS2c;
      if (v) begin
         if (mRun > 0 && c == mRunCode) mRun++;
         else begin mRun = 1; mRunCode = c; end
         mRel = 0;
      end else begin
         mRun = 0; mRel++;
      end
      fire = mArmed && v && (mRun == DEB);
      if (fire) mArmed = 1'b0;
      else if (!v && mRel >= DEB) mArmed = 1'b1;
      expire = (limitOf(mState) > 0) && (mLeft == 1);
      nxt = mState; reload = 0;
      case (mState)
         S_IDLE: if (fire && c <= 4'd9) begin mBuf = {12'd0, c}; mCount = 1; nxt = S_ENTRY; end
         S_ENTRY, S_PROGRAM: begin
            if (expire) begin nxt = S_IDLE; mBuf = '0; mCount = 0; end
            else if (fire) begin
               reload = 1;
               if (c <= 4'd9) begin
                  if (mCount < 4) begin mBuf = {mBuf[11:0], c}; mCount++; end
               end else if (c == 4'hC) begin
                  nxt = (mState == S_ENTRY) ? S_IDLE : S_UNLOCKED; mBuf = '0; mCount = 0;
               end else if (c == 4'hA) begin
                  if (mState == S_ENTRY) nxt = S_CHECK;
                  else begin
                     if (mCount == 4) begin mCode = mBuf; nxt = S_UNLOCKED; end
                     else nxt = S_ERROR;
                     mBuf = '0; mCount = 0;
                  end
               end
            end
         end
         S_CHECK: begin
            if (mCount == 4 && mBuf == mCode) begin mFails = 0; nxt = S_UNLOCKED; end
            else begin
               if (mFails < 3) mFails++;
               nxt = (mFails == 3) ? S_LOCKOUT : S_ERROR;
            end
            mBuf = '0; mCount = 0;
         end
         S_UNLOCKED: begin
            if (expire) nxt = S_IDLE;
            else if (fire && c == 4'hD) nxt = S_IDLE;
            else if (fire && c == 4'hB) nxt = S_PROGRAM;
         end
         S_ERROR:   if (expire) nxt = S_IDLE;
         S_LOCKOUT: if (expire) begin nxt = S_IDLE; mFails = 0; if (v) mArmed = 1'b0; end
         default:   nxt = S_IDLE;
      endcase
      if (nxt != mState) mLeft = limitOf(nxt);
      else if (reload) mLeft = limitOf(mState);
      else if (mLeft > 0) mLeft--;
      mState = nxt;
      mS2v = mS1v; mS2c = mS1c; mS1v = keyValid; mS1c = keyCode;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else modelStep();
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cmpEn) begin
         checkOutput("cyc_state",  int'(stateOut),   mState);
         checkOutput("cyc_digits", int'(digitCount), mCount);
         checkOutput("cyc_fails",  int'(failCnt),    mFails);
         checkOutput("cyc_unlock", int'(unlock), (mState == S_UNLOCKED || mState == S_PROGRAM) ? 1 : 0);
         checkOutput("cyc_error",  int'(error),  (mState == S_ERROR) ? 1 : 0);
         checkOutput("cyc_alarm",  int'(alarm),  (mState == S_LOCKOUT) ? 1 : 0);
      end
   end

   // Lengths of the most recent unlock/error/alarm pulses, in cycles
   always @(negedge clk) begin
      if (unlock) unlockRun++;
      else if (unlockRun > 0) begin lastUnlockRun = unlockRun; unlockRun = 0; end
      if (error) errorRun++;
      else if (errorRun > 0) begin lastErrorRun = errorRun; errorRun = 0; end
      if (alarm) alarmRun++;
      else if (alarmRun > 0) begin lastAlarmRun = alarmRun; alarmRun = 0; end
   end

   task automatic applyStimulus(input logic [3:0] k, input int hold, input int rel);
      keyCode  = k;
      keyValid = 1'b1;
      repeat (hold) @(negedge clk);
      keyValid = 1'b0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic enterCode(input logic [15:0] pin);
      logic [3:0] nib;
      for (int i = 3; i >= 0; i--) begin
         nib = pin[4*i +: 4];
         applyStimulus(nib, 10, 10);
      end
      applyStimulus(4'hA, 10, 10);
   endtask

   initial begin
      rst_n = 1'b0; keyValid = 1'b0; keyCode = 4'h0;
      repeat (3) @(negedge clk);
      checkOutput("rst_state",  int'(stateOut),   0);
      checkOutput("rst_unlock", int'(unlock),     0);
      checkOutput("rst_digits", int'(digitCount), 0);
      checkOutput("rst_fails",  int'(failCnt),    0);
      checkOutput("rst_alarm",  int'(alarm | error), 0);
      rst_n = 1'b1;
      cmpEn = 1;
      repeat (5) @(negedge clk);

      // correct PIN opens the door for exactly the unlock time
      enterCode(16'h1234);
      checkOutput("t1_state",       int'(stateOut), 3);
      checkOutput("t1_model_state", mState, 3);
      checkOutput("t1_unlock",      int'(unlock), 1);
      repeat (60) @(negedge clk);
      checkOutput("t1_unlock_len",  lastUnlockRun, 50);
      checkOutput("t1_idle",        int'(stateOut), 0);
      checkOutput("t1_fails",       int'(failCnt), 0);

      // bouncing key 5 then a long hold gives one press
      keyCode = 4'h5;
      for (int i = 0; i < 6; i++) begin
         keyValid = (i == 2 || i == 3) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      keyValid = 1'b1;
      repeat (100) @(negedge clk);
      keyValid = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("t2_digits",       int'(digitCount), 1);
      checkOutput("t2_model_digits", mCount, 1);
      checkOutput("t2_state",        int'(stateOut), 1);
      applyStimulus(4'hC, 10, 10);
      checkOutput("t2_cleared", int'(stateOut), 0);

      // three wrong PINs: two errors, then lockout
      for (int a = 1; a <= 2; a++) begin
         enterCode(16'h1235);
         checkOutput("t3_err_state", int'(stateOut), 5);
         checkOutput("t3_fails",     int'(failCnt), a);
         repeat (15) @(negedge clk);
         checkOutput("t3_err_len",   lastErrorRun, 20);
      end
      enterCode(16'h1235);
      checkOutput("t3_lock_state", int'(stateOut), 6);
      checkOutput("t3_lock_alarm", int'(alarm), 1);
      applyStimulus(4'h7, 10, 10);
      applyStimulus(4'h8, 10, 10);
      checkOutput("t3_lock_digits", int'(digitCount), 0);
      checkOutput("t3_lock_still",  int'(stateOut), 6);
      repeat (40) @(negedge clk);
      checkOutput("t3_alarm_len",  lastAlarmRun, 80);
      checkOutput("t3_after_fail", int'(failCnt), 0);
      checkOutput("t3_after_idle", int'(stateOut), 0);

      // reprogram to 9876
      enterCode(16'h1234);
      applyStimulus(4'hB, 10, 10);
      checkOutput("t4_program", int'(stateOut), 4);
      applyStimulus(4'h9, 10, 10);
      applyStimulus(4'h8, 10, 10);
      applyStimulus(4'h7, 10, 10);
      applyStimulus(4'h6, 10, 10);
      applyStimulus(4'hA, 10, 10);
      checkOutput("t4_unlocked", int'(stateOut), 3);
      repeat (30) @(negedge clk);
      checkOutput("t4_timer_restart", int'(stateOut), 3);
      repeat (10) @(negedge clk);
      checkOutput("t4_expired", int'(stateOut), 0);
      enterCode(16'h1234);
      checkOutput("t4_old_code", int'(stateOut), 5);
      checkOutput("t4_old_fail", int'(failCnt), 1);
      repeat (10) @(negedge clk);
      enterCode(16'h9876);
      checkOutput("t4_new_code", int'(stateOut), 3);
      checkOutput("t4_new_fail", int'(failCnt), 0);
      applyStimulus(4'hD, 10, 10);
      checkOutput("t4_locked", int'(stateOut), 0);

      // entry timeout boundary and clear key
      applyStimulus(4'h1, 10, 10);
      applyStimulus(4'h2, 10, 10);
      repeat (170) @(negedge clk);
      checkOutput("t5_before_to", int'(stateOut), 1);
      checkOutput("t5_digits",    int'(digitCount), 2);
      repeat (20) @(negedge clk);
      checkOutput("t5_after_to",  int'(stateOut), 0);
      checkOutput("t5_to_digits", int'(digitCount), 0);
      applyStimulus(4'h1, 10, 10);
      applyStimulus(4'h2, 10, 10);
      applyStimulus(4'h3, 10, 10);
      checkOutput("t5_three", int'(digitCount), 3);
      applyStimulus(4'hC, 10, 10);
      checkOutput("t5_clr_state",  int'(stateOut), 0);
      checkOutput("t5_clr_digits", int'(digitCount), 0);

      // reset in the middle of programming restores the default code
      enterCode(16'h9876);
      applyStimulus(4'hB, 10, 10);
      applyStimulus(4'h1, 10, 10);
      applyStimulus(4'h2, 10, 10);
      checkOutput("t6_prog_state",  int'(stateOut), 4);
      checkOutput("t6_prog_digits", int'(digitCount), 2);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_state",  int'(stateOut), 0);
      checkOutput("t6_rst_unlock", int'(unlock), 0);
      checkOutput("t6_rst_digits", int'(digitCount), 0);
      checkOutput("t6_rst_fails",  int'(failCnt), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      enterCode(16'h1234);
      checkOutput("t6_default_code", int'(stateOut), 3);
      applyStimulus(4'hD, 10, 10);
      checkOutput("t6_final_idle", int'(stateOut), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
      $finish;
   end

endmodule
